// File: rtl/key_165_rd.sv
// -----------------------------------------------------------------------------
// key_165_rd
//   Periodically scans a chain of cascaded 74HC165 parallel-in/serial-out
//   shift registers and presents the key state as a parallel vector.
//   A frame is: parallel load (LOAD), KEY_NUM shift clocks (SHIFT), and a
//   one-cycle update step (DONE). Inputs are pulled up, so a pressed key
//   reads 0 and the captured frame is inverted.
//
//   Optional feature: define KEY_165_DEBOUNCE_EN to require DEB_CNT
//   identical consecutive frames before key_val is updated. Without the
//   macro, key_val is rewritten after every frame.
//
// Ports
//   clk        in   sole clock
//   rst_n      in   asynchronous active-low reset
//   q7_165     in   serial data from the last 74HC165 in the chain
//   pl_165     out  active-low parallel load
//   cp_165     out  shift clock
//   ce_165     out  active-low clock enable
//   key_val    out  [KEY_NUM] debounced key state, 1 = pressed
//   key_vld    out  one-cycle pulse when key_val is written
//   key_press  out  [KEY_NUM] one-cycle pulse per bit on a 0->1 key_val edge
// -----------------------------------------------------------------------------
module key_165_rd #(
  parameter int unsigned CLK_DIV     = 25,
  parameter int unsigned KEY_NUM     = 16,
  parameter int unsigned SCAN_PERIOD = 1000000,
  parameter int unsigned DEB_CNT     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               q7_165,
  output logic               pl_165,
  output logic               cp_165,
  output logic               ce_165,
  output logic [KEY_NUM-1:0] key_val,
  output logic               key_vld,
  output logic [KEY_NUM-1:0] key_press
);

  localparam int unsigned SCAN_W = $clog2(SCAN_PERIOD);
  localparam int unsigned DIV_W  = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_W  = $clog2(KEY_NUM);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HIGH  = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_SAMP  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(KEY_NUM - 1);

  if (CLK_DIV < 1 || KEY_NUM < 8 || KEY_NUM > 32 || DEB_CNT < 1 ||
      SCAN_PERIOD <= 2 * CLK_DIV * (KEY_NUM + 1) + 2) begin : g_bad_param
    $error("key_165_rd: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [KEY_NUM-1:0] raw_q, raw_d;
  logic               pl_q, pl_d;
  logic               cp_q, cp_d;
  logic               ce_q, ce_d;
  logic [KEY_NUM-1:0] key_val_q, key_val_d;
  logic               key_vld_q, key_vld_d;
  logic [KEY_NUM-1:0] key_press_q, key_press_d;
  logic [KEY_NUM-1:0] frame;
  logic               tick;
  logic               upd;

`ifdef KEY_165_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEB_CNT + 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CNT);
  localparam logic [DEB_W-1:0] DEB_HIT  = DEB_W'(DEB_CNT - 1);

  logic [KEY_NUM-1:0] prev_q, prev_d;
  logic [DEB_W-1:0]   stab_q, stab_d;
  logic               match;
`endif

  assign tick  = (scan_q == SCAN_LAST);
  assign frame = ~raw_q;

  always_comb begin
    scan_d      = tick ? '0 : scan_q + 1'b1;
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    raw_d       = raw_q;
    key_val_d   = key_val_q;
    key_vld_d   = 1'b0;
    key_press_d = '0;
    upd         = 1'b0;
`ifdef KEY_165_DEBOUNCE_EN
    prev_d      = prev_q;
    stab_d      = stab_q;
    match       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (tick) state_d = LOAD;
      end
      LOAD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        // Last cycle of the cp low phase: data has settled since the previous rise.
        if (div_q == DIV_SAMP) raw_d = {raw_q[KEY_NUM-2:0], q7_165};
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) state_d = DONE;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef KEY_165_DEBOUNCE_EN
        match  = (frame == prev_q);
        prev_d = frame;
        if (!match)                stab_d = '0;
        else if (stab_q != DEB_MAX) stab_d = stab_q + 1'b1;
        // Fire only on the frame that first completes the stable run.
        upd = (stab_d == DEB_HIT) && (!match || stab_q != DEB_HIT) &&
              (frame != key_val_q);
`else
        upd = 1'b1;
`endif
        if (upd) begin
          key_val_d   = frame;
          key_vld_d   = 1'b1;
          key_press_d = frame & ~key_val_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with state_q.
    pl_d = (state_d != LOAD);
    ce_d = (state_d != SHIFT);
    cp_d = (state_d == SHIFT) && (div_d >= DIV_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scan_q      <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      raw_q       <= '0;
      pl_q        <= 1'b1;
      cp_q        <= 1'b0;
      ce_q        <= 1'b1;
      key_val_q   <= '0;
      key_vld_q   <= 1'b0;
      key_press_q <= '0;
`ifdef KEY_165_DEBOUNCE_EN
      prev_q      <= '0;
      stab_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      scan_q      <= scan_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      raw_q       <= raw_d;
      pl_q        <= pl_d;
      cp_q        <= cp_d;
      ce_q        <= ce_d;
      key_val_q   <= key_val_d;
      key_vld_q   <= key_vld_d;
      key_press_q <= key_press_d;
`ifdef KEY_165_DEBOUNCE_EN
      prev_q      <= prev_d;
      stab_q      <= stab_d;
`endif
    end
  end

  assign pl_165    = pl_q;
  assign cp_165    = cp_q;
  assign ce_165    = ce_q;
  assign key_val   = key_val_q;
  assign key_vld   = key_vld_q;
  assign key_press = key_press_q;

endmodule

// File: tb/tb_key_165_rd.sv
module tb_key_165_rd;
  localparam int CD = 2;
  localparam int KN = 16;
  localparam int SP = 100;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          q7_165;
  logic          pl_165, cp_165, ce_165, key_vld;
  logic [KN-1:0] key_val, key_press;

  key_165_rd #(.CLK_DIV(CD), .KEY_NUM(KN), .SCAN_PERIOD(SP), .DEB_CNT(DC)) dut (
    .clk(clk), .rst_n(rst_n), .q7_165(q7_165),
    .pl_165(pl_165), .cp_165(cp_165), .ce_165(ce_165),
    .key_val(key_val), .key_vld(key_vld), .key_press(key_press)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // 74HC165 chain model: async parallel load while PL low, shift on CP rise
  // when CE low, serial-in tied high.
  logic [KN-1:0] load_val = '1;
  logic [KN-1:0] sr = '1;
  always @(negedge pl_165 or posedge cp_165) begin
    if (!pl_165)     sr <= load_val;
    else if (!ce_165) sr <= {sr[KN-2:0], 1'b1};
  end
  assign q7_165 = pl_165 ? sr[KN-1] : load_val[KN-1];

  int cp_edges = 0;
  always @(posedge cp_165) cp_edges++;

  // Behavioural reference: key i pressed <=> parallel input i reads 0.
  logic [KN-1:0] m_val;
  logic [KN-1:0] hist[$];

  function automatic void model_reset();
    m_val = '0;
    hist = {};
    hist.push_back('0);
  endfunction

  task automatic model_frame(input logic [KN-1:0] load, output logic [KN-1:0] e_val,
                             output logic e_vld, output logic [KN-1:0] e_press);
    logic [KN-1:0] f;
    logic upd;
    int run;
    f = ~load;
`ifdef KEY_165_DEBOUNCE_EN
    hist.push_back(f);
    if (hist.size() > 8) void'(hist.pop_front());
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != f) break;
      run++;
    end
    upd = (run == DC) && (f != m_val);
`else
    run = 0;
    upd = 1'b1;
`endif
    e_vld   = upd;
    e_press = upd ? (f & ~m_val) : '0;
    if (upd) m_val = f;
    e_val = m_val;
  endtask

  task automatic run_frame(input string tag, input logic [KN-1:0] load, input logic [KN-1:0] e_val,
                           input logic e_vld, input logic [KN-1:0] e_press);
    bit found;
    int pl_low, ce_low;
    load_val = load;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!pl_165) begin found = 1; break; end
    end
    check({tag, "_start"}, found, 1);
    if (!found) return;
    pl_low = 1;
    ce_low = 0;
    for (int i = 0; i < 67; i++) begin
      @(negedge clk);
      if (!pl_165) pl_low++;
      if (!ce_165) ce_low++;
    end
    @(negedge clk);  // DONE cycle
    check({tag, "_pl_low_cycles"}, pl_low, 4);
    check({tag, "_ce_low_cycles"}, ce_low, 64);
    check({tag, "_cp_edges"}, cp_edges, KN);
    check({tag, "_vld_in_done"}, key_vld, 0);
    @(negedge clk);
    check({tag, "_key_val"}, key_val, e_val);
    check({tag, "_key_vld"}, key_vld, e_vld);
    check({tag, "_key_press"}, key_press, e_press);
    @(negedge clk);
    check({tag, "_vld_after"}, key_vld, 0);
    check({tag, "_press_after"}, key_press, 0);
    cp_edges = 0;
  endtask

  typedef struct {
    logic [KN-1:0] load;
    logic [KN-1:0] val;
    logic          vld;
    logic [KN-1:0] press;
  } vec_t;
  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [KN-1:0] e_val, e_press, ld, prev_ld;
    logic e_vld;
    bit found;
    int k;

`ifdef KEY_165_DEBOUNCE_EN
    vecs.push_back('{16'hFFFE, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{16'hFFFE, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{16'hFFFE, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{16'hFFFE, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{16'hFFFE, 16'h0001, 1'b1, 16'h0001});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 16'h0000});
`else
    vecs.push_back('{16'hFFFE, 16'h0001, 1'b1, 16'h0001});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 16'h0000});
    vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 16'h8000});
    vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 16'h0000});
`endif

    // Reset values while held.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pl", pl_165, 1);
    check("rst_cp", cp_165, 0);
    check("rst_ce", ce_165, 1);
    check("rst_key_val", key_val, 0);
    check("rst_key_vld", key_vld, 0);
    check("rst_key_press", key_press, 0);

    // Reset during the shift phase aborts the frame.
    load_val = 16'hFFFE;
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!pl_165) begin found = 1; break; end
    end
    check("midrst_frame_start", found, 1);
    cp_edges = 0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cp_edges >= 7) begin found = 1; break; end
    end
    check("midrst_reach_bit7", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pl", pl_165, 1);
    check("midrst_cp", cp_165, 0);
    check("midrst_ce", ce_165, 1);
    check("midrst_key_val", key_val, 0);
    check("midrst_key_vld", key_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (!pl_165) begin k = i; break; end
    end
    check("midrst_restart_cycles", k, SP);

    // Clean reset before the frame table.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cp_edges = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      model_frame(vecs[i].load, e_val, e_vld, e_press);
      run_frame($sformatf("vec%0d", i), vecs[i].load, vecs[i].val, vecs[i].vld, vecs[i].press);
    end

    // Randomized frames against the reference model; repeats exercise debounce.
    prev_ld = vecs[vecs.size()-1].load;
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        ld = prev_ld;
      end else begin
        case ($urandom_range(0, 3))
          0: ld = 16'hFFFE;
          1: ld = 16'h7FFF;
          2: ld = 16'hFFFF;
          default: ld = 16'($urandom);
        endcase
      end
      prev_ld = ld;
      model_frame(ld, e_val, e_vld, e_press);
      run_frame($sformatf("rnd%0d", i), ld, e_val, e_vld, e_press);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
